// File: rtl/divider_remainder_engine.sv
// Restoring shift-subtract divider: one quotient bit per clock behind a start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement signed division (adds one FIX cycle after ITER).
module divider_remainder_engine #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             divisor_wr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] dreg_q;
    logic [CNT_W-1:0] count_q;
    logic             zero_q;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

`ifdef DIV_SIGNED_EN
    logic nsign_q;
    logic dsign_q;

    assign dividend_abs = lo_q[WIDTH-1] ? -lo_q : lo_q;
    assign divisor_abs  = divisor_in[WIDTH-1] ? -divisor_in : divisor_in;
`else
    assign dividend_abs = lo_q;
    assign divisor_abs  = divisor_in;
`endif

    // The partial remainder is WIDTH+1 bits; when it is >= dreg the true
    // difference fits in WIDTH bits, so the low WIDTH bits of the subtraction suffice.
    logic [WIDTH:0]   partial;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign partial    = {hi_q, lo_q[WIDTH-1]};
    assign trial_ge   = partial >= {1'b0, dreg_q};
    assign trial_diff = partial[WIDTH-1:0] - dreg_q;

    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        hi_d = partial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], trial_ge};
        if (trial_ge) begin
            hi_d = trial_diff;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            dreg_q      <= '0;
            count_q     <= '0;
            zero_q      <= 1'b0;
            divisor_wr  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            nsign_q     <= 1'b0;
            dsign_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lo_q        <= dividend_in;
                        hi_q        <= '0;
                        count_q     <= '0;
                        div_by_zero <= 1'b0;
                        divisor_wr  <= 1'b1;
                        busy        <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    divisor_wr <= 1'b0;
`ifdef DIV_SIGNED_EN
                    nsign_q    <= lo_q[WIDTH-1];
                    dsign_q    <= divisor_in[WIDTH-1];
`endif
                    if (divisor_in == '0) begin
                        // Skip the iterations; the raw dividend becomes the remainder.
                        dreg_q  <= '0;
                        lo_q    <= '1;
                        hi_q    <= lo_q;
                        zero_q  <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        dreg_q  <= divisor_abs;
                        lo_q    <= dividend_abs;
                        zero_q  <= 1'b0;
                        state_q <= S_ITER;
                    end
                end

                S_ITER: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
                        state_q <= S_FIX;
`else
                        busy    <= 1'b0;
                        state_q <= S_DONE;
`endif
                    end
                end

                S_FIX: begin
`ifdef DIV_SIGNED_EN
                    // MIN / -1 falls out naturally: |MIN|/1 negated wraps back to MIN.
                    lo_q <= (nsign_q ^ dsign_q) ? -lo_q : lo_q;
                    hi_q <= nsign_q ? -hi_q : hi_q;
`endif
                    busy    <= 1'b0;
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    quotient    <= lo_q;
                    remainder   <= hi_q;
                    div_by_zero <= zero_q;
                    done        <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    divisor_wr <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
